// File: rtl/uart_rx_decoder_pkg.sv
// Definitions shared by both ends of the serial link: receiver FSM states, cipher
// modes and the Hamming (7,4) syndrome-to-bit table.
package uart_rx_decoder_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_DONE
   } rx_state_t;

   localparam int CW_BITS   = 7;
   localparam int DATA_BITS = 4;

   localparam int OP_NOT       = 1;
   localparam int OP_ROT_R     = 2;
   localparam int OP_ROT_L     = 3;
   localparam int OP_ROT_L_NOT = 4;

   // One-hot mask of the codeword bit a syndrome points at; 000 flips nothing.
   function automatic logic [6:0] syndrome_flip(input logic [2:0] syn);
      logic [6:0] mask;
      case (syn)
         3'b111:  mask = 7'b100_0000;
         3'b101:  mask = 7'b010_0000;
         3'b110:  mask = 7'b001_0000;
         3'b011:  mask = 7'b000_1000;
         3'b100:  mask = 7'b000_0100;
         3'b010:  mask = 7'b000_0010;
         3'b001:  mask = 7'b000_0001;
         default: mask = 7'b000_0000;
      endcase
      return mask;
   endfunction

endpackage

// File: rtl/uart_rx_decoder_hamming74_decoder.sv
// Combinational Hamming (7,4) decoder: received codeword in, single-bit corrected
// encrypted nibble, syndrome and a corrected-error flag out.
module hamming74_decoder
   import uart_rx_decoder_pkg::*;
(
   input  logic [6:0] codeword,
   output logic [3:0] data,
   output logic [2:0] syndrome,
   output logic       err
);

   logic [6:0] flip;

   assign syndrome = {codeword[2] ^ codeword[6] ^ codeword[5] ^ codeword[4],
                      codeword[1] ^ codeword[6] ^ codeword[4] ^ codeword[3],
                      codeword[0] ^ codeword[6] ^ codeword[5] ^ codeword[3]};

   // Parity-bit hits still count as corrected even though the data nibble is untouched.
   assign flip = syndrome_flip(syndrome);
   assign data = codeword[6:3] ^ flip[6:3];
   assign err  = |flip;

endmodule

// File: rtl/uart_rx_decoder.sv
// Receive end of the serial link: frames a 9-bit line burst on the transmitter's load
// strobe, corrects it through the Hamming (7,4) decoder and undoes the cipher.
module uart_rx_decoder
   import uart_rx_decoder_pkg::*;
#(
   parameter int N     = 7,
   parameter int K     = 4,
   parameter int OpFun = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         data_in,
   output logic [K-1:0] data_out,
   output logic         data_valid,
   output logic         err_corrected,
   output logic         frame_err,
   output logic         overrun,
   output logic [2:0]   syndrome,
   output logic         busy,
   output logic [N-1:0] led_codeword
);

   if (N != CW_BITS) begin : g_bad_n
      $error("uart_rx_decoder: N must be 7");
   end
   if (K != DATA_BITS) begin : g_bad_k
      $error("uart_rx_decoder: K must be 4");
   end
   if (OpFun < OP_NOT || OpFun > OP_ROT_L_NOT) begin : g_bad_op
      $error("uart_rx_decoder: OpFun must be 1..4");
   end

   rx_state_t  state;
   rx_state_t  state_next;
   logic       abort;
   logic [2:0] bit_cnt;
   logic [6:0] shift_reg;
   logic       frame_err_pend;
   logic [3:0] enc_data;
   logic [3:0] plain_data;
   logic [2:0] dec_syndrome;
   logic       dec_err;

   hamming74_decoder u_hamming (
      .codeword (shift_reg),
      .data     (enc_data),
      .syndrome (dec_syndrome),
      .err      (dec_err)
   );

   always_comb begin
      case (OpFun)
         OP_NOT:       plain_data = ~enc_data;
         OP_ROT_R:     plain_data = {enc_data[0], enc_data[3:1]};
         OP_ROT_L:     plain_data = {enc_data[2:0], enc_data[3]};
         OP_ROT_L_NOT: plain_data = {~enc_data[2:0], ~enc_data[3]};
         default:      plain_data = ~enc_data;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // A load in DONE is the next frame arriving on schedule (every 10 clk): the current
   // frame is already complete, so it is delivered and not reported as an overrun.
   always_comb begin
      state_next = state;
      abort      = 1'b0;
      case (state)
         S_IDLE:  if (load) state_next = S_START;
         S_START: state_next = S_DATA;
         S_DATA:  if (bit_cnt == 3'd6) state_next = S_STOP;
         S_STOP:  state_next = S_DONE;
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
      if (load) begin
         state_next = S_START;
         abort      = (state == S_START) || (state == S_DATA) || (state == S_STOP);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt        <= 3'd0;
         shift_reg      <= 7'd0;
         frame_err_pend <= 1'b0;
         data_out       <= '0;
         data_valid     <= 1'b0;
         err_corrected  <= 1'b0;
         frame_err      <= 1'b0;
         overrun        <= 1'b0;
         syndrome       <= 3'd0;
         led_codeword   <= '0;
      end else begin
         data_valid    <= 1'b0;
         err_corrected <= 1'b0;
         frame_err     <= 1'b0;
         overrun       <= abort;
         case (state)
            S_START: begin
               frame_err_pend <= data_in;
               bit_cnt        <= 3'd0;
            end
            // LSB arrives first, so shifting in from the top leaves r[0] at bit 0.
            S_DATA: begin
               shift_reg <= {data_in, shift_reg[6:1]};
               bit_cnt   <= bit_cnt + 3'd1;
            end
            S_STOP: begin
               if (!data_in) frame_err_pend <= 1'b1;
            end
            S_DONE: begin
               data_out      <= plain_data;
               syndrome      <= dec_syndrome;
               err_corrected <= dec_err;
               frame_err     <= frame_err_pend;
               led_codeword  <= shift_reg;
               data_valid    <= 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_decoder.sv
// Self-checking bench: four receivers (one per cipher mode) fed by a behavioural
// transmitter model built from the codeword layout and cipher definitions.
module tb_uart_rx_decoder;

   localparam logic [8:0] SPEC_FRAME = 9'b1_0101_1100;
   localparam logic [2:0] POS_SYN [7] = '{3'b001, 3'b010, 3'b100, 3'b011,
                                          3'b110, 3'b101, 3'b111};

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   logic load  = 1'b0;
   logic [3:0] line = '0;

   logic [3:0][3:0] dout;
   logic [3:0][2:0] syn;
   logic [3:0][6:0] led;
   logic [3:0]      dv, ecor, ferr, ovr, bsy;

   int errors = 0;
   int checks = 0;
   logic [3:0] held;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : lane
      uart_rx_decoder #(.N(7), .K(4), .OpFun(g + 1)) dut (
         .clk           (clk),
         .rst_n         (rst_n),
         .load          (load),
         .data_in       (line[g]),
         .data_out      (dout[g]),
         .data_valid    (dv[g]),
         .err_corrected (ecor[g]),
         .frame_err     (ferr[g]),
         .overrun       (ovr[g]),
         .syndrome      (syn[g]),
         .busy          (bsy[g]),
         .led_codeword  (led[g])
      );
   end

   // Transmitter-side cipher: the inverse of each receiver decryption mode.
   function automatic logic [3:0] encrypt(input logic [3:0] d, input int mode);
      case (mode)
         1:       return ~d;
         2:       return {d[2:0], d[3]};
         3:       return {d[0], d[3:1]};
         default: return ~{d[0], d[3:1]};
      endcase
   endfunction

   function automatic logic [6:0] codeword(input logic [3:0] e);
      return {e, e[3] ^ e[2] ^ e[1], e[3] ^ e[1] ^ e[0], e[3] ^ e[2] ^ e[0]};
   endfunction

   // Line bits per lane, bit 0 sent first: start, r[0..6], stop.
   function automatic logic [3:0][8:0] build(input logic [3:0] d, input logic [6:0] flip,
                                             input logic start_bit, input logic stop_bit);
      logic [3:0][8:0] f;
      for (int l = 0; l < 4; l++) f[l] = {stop_bit, codeword(encrypt(d, l + 1)) ^ flip, start_bit};
      return f;
   endfunction

   task automatic drive_frame(input logic [3:0][8:0] f);
      @(negedge clk);
      load = 1'b1;
      line = '0;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         load = 1'b0;
         for (int l = 0; l < 4; l++) line[l] = f[l][i];
      end
   endtask

   task automatic finish_frame();
      @(negedge clk);
      line = '0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      #2 rst_n = 1'b0;
      #10;
      checks++;
      if ({dout, syn, led, dv, ecor, ferr, ovr, bsy} !== '0) begin
         errors++;
         $display("[TB] FAIL reset_outputs: got %h want 0", {dout, syn, led, dv, ecor, ferr, ovr, bsy});
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_clean();
      logic [3:0][8:0] f;
      f    = build(4'b1010, 7'd0, 1'b0, 1'b1);
      f[0] = SPEC_FRAME;
      drive_frame(f);
      finish_frame();
      checks++;
      if (dv !== 4'hF || dout !== {4{4'b1010}}) begin
         errors++;
         $display("[TB] FAIL clean_data: got dv=%b data=%h want dv=1111 data=aaaa", dv, dout);
      end
      checks++;
      if (syn[0] !== 3'b000 || ecor[0] !== 1'b0 || ferr[0] !== 1'b0) begin
         errors++;
         $display("[TB] FAIL clean_flags: got syn=%b ec=%b fe=%b want 000 0 0", syn[0], ecor[0], ferr[0]);
      end
      checks++;
      if (led[0] !== 7'b0101110) begin
         errors++;
         $display("[TB] FAIL clean_codeword: got %b want 0101110", led[0]);
      end
      @(negedge clk);
      checks++;
      if (dv !== 4'h0) begin
         errors++;
         $display("[TB] FAIL valid_pulse_width: got %b want 0000", dv);
      end
   endtask

   task automatic test_end_to_end();
      for (int d = 0; d < 16; d++) begin
         drive_frame(build(d[3:0], 7'd0, 1'b0, 1'b1));
         finish_frame();
         checks++;
         if (dv !== 4'hF || dout !== {4{d[3:0]}} || syn !== '0 || ecor !== 4'h0) begin
            errors++;
            $display("[TB] FAIL end_to_end d=%h: got dv=%b data=%h syn=%h ec=%b want 1111 %h 0 0",
                     d[3:0], dv, dout, syn, ecor, {4{d[3:0]}});
         end
      end
   endtask

   task automatic test_single_error();
      logic [3:0] d;
      int pos;
      for (int n = 0; n < 10; n++) begin
         d   = (n < 2) ? 4'b1010 : 4'($urandom_range(0, 15));
         pos = (n == 0) ? 5 : (n == 1) ? 1 : int'($urandom_range(0, 6));
         drive_frame(build(d, 7'(1 << pos), 1'b0, 1'b1));
         finish_frame();
         checks++;
         if (dv !== 4'hF || dout !== {4{d}}) begin
            errors++;
            $display("[TB] FAIL single_err_data pos=%0d: got dv=%b data=%h want 1111 %h", pos, dv, dout, {4{d}});
         end
         checks++;
         if (syn !== {4{POS_SYN[pos]}} || ecor !== 4'hF) begin
            errors++;
            $display("[TB] FAIL single_err_syndrome pos=%0d: got syn=%h ec=%b want %h 1111",
                     pos, syn, ecor, {4{POS_SYN[pos]}});
         end
      end
   endtask

   task automatic test_framing();
      logic [3:0] d;
      for (int n = 0; n < 2; n++) begin
         d = 4'($urandom_range(0, 15));
         drive_frame(build(d, 7'd0, n == 1, n == 1));
         finish_frame();
         checks++;
         if (dv !== 4'hF || ferr !== 4'hF || dout !== {4{d}}) begin
            errors++;
            $display("[TB] FAIL framing case=%0d: got dv=%b fe=%b data=%h want 1111 1111 %h",
                     n, dv, ferr, dout, {4{d}});
         end
         held = d;
      end
   endtask

   task automatic test_overrun();
      logic [3:0][8:0] fa, fb;
      logic [3:0] db;
      int early;
      fa = build(4'($urandom_range(0, 15)), 7'd0, 1'b0, 1'b1);
      db = 4'($urandom_range(0, 15));
      fb = build(db, 7'd0, 1'b0, 1'b1);
      early = 0;
      fork
         begin
            @(negedge clk);
            load = 1'b1;
            for (int i = 0; i < 3; i++) begin
               @(negedge clk);
               load = 1'b0;
               for (int l = 0; l < 4; l++) line[l] = fa[l][i];
            end
            drive_frame(fb);
            @(negedge clk);
            line = '0;
         end
         begin
            for (int n = 1; n <= 16; n++) begin
               @(negedge clk);
               if (n >= 2 && n <= 15 && dv !== 4'h0) early++;
               if (n == 6) begin
                  checks++;
                  if (ovr !== 4'hF) begin
                     errors++;
                     $display("[TB] FAIL overrun_pulse: got %b want 1111", ovr);
                  end
               end
               if (n == 7) begin
                  checks++;
                  if (ovr !== 4'h0) begin
                     errors++;
                     $display("[TB] FAIL overrun_width: got %b want 0000", ovr);
                  end
               end
               if (n == 15) begin
                  checks++;
                  if (dout !== {4{held}}) begin
                     errors++;
                     $display("[TB] FAIL overrun_hold: got %h want %h", dout, {4{held}});
                  end
               end
               if (n == 16) begin
                  checks++;
                  if (dv !== 4'hF || dout !== {4{db}}) begin
                     errors++;
                     $display("[TB] FAIL overrun_frame2: got dv=%b data=%h want 1111 %h", dv, dout, {4{db}});
                  end
               end
            end
         end
      join
      checks++;
      if (early != 0) begin
         errors++;
         $display("[TB] FAIL overrun_aborted_valid: got %0d pulses want 0", early);
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] da, db;
      int ov_seen;
      da = 4'($urandom_range(0, 15));
      db = ~da;
      ov_seen = 0;
      fork
         begin
            drive_frame(build(da, 7'd0, 1'b0, 1'b1));
            drive_frame(build(db, 7'd0, 1'b0, 1'b1));
            @(negedge clk);
            line = '0;
         end
         begin
            for (int n = 1; n <= 22; n++) begin
               @(negedge clk);
               if (ovr !== 4'h0) ov_seen++;
               if (n == 12 || n == 22) begin
                  checks++;
                  if (dv !== 4'hF || dout !== {4{(n == 12) ? da : db}}) begin
                     errors++;
                     $display("[TB] FAIL back_to_back n=%0d: got dv=%b data=%h want 1111 %h",
                              n, dv, dout, {4{(n == 12) ? da : db}});
                  end
               end
            end
         end
      join
      checks++;
      if (ov_seen != 0) begin
         errors++;
         $display("[TB] FAIL back_to_back_overrun: got %0d cycles want 0", ov_seen);
      end
   endtask

   task automatic test_async_reset();
      logic [3:0][8:0] f;
      logic [3:0] d;
      drive_frame(build(4'b0110, 7'd0, 1'b0, 1'b1));
      finish_frame();
      f = build(4'b1001, 7'd0, 1'b0, 1'b1);
      @(negedge clk);
      load = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         load = 1'b0;
         for (int l = 0; l < 4; l++) line[l] = f[l][i];
      end
      checks++;
      if (bsy !== 4'hF) begin
         errors++;
         $display("[TB] FAIL busy_mid_frame: got %b want 1111", bsy);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({dout, syn, led, dv, ecor, ferr, ovr, bsy} !== '0) begin
         errors++;
         $display("[TB] FAIL async_reset: got %h want 0", {dout, syn, led, dv, ecor, ferr, ovr, bsy});
      end
      @(negedge clk);
      rst_n = 1'b1;
      d = 4'($urandom_range(0, 15));
      drive_frame(build(d, 7'd0, 1'b0, 1'b1));
      finish_frame();
      checks++;
      if (dv !== 4'hF || dout !== {4{d}} || ferr !== 4'h0) begin
         errors++;
         $display("[TB] FAIL after_reset: got dv=%b data=%h fe=%b want 1111 %h 0000", dv, dout, ferr, {4{d}});
      end
   endtask

   initial begin
      test_reset();
      test_clean();
      test_end_to_end();
      test_single_error();
      test_framing();
      test_overrun();
      test_back_to_back();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
